// File: rtl/hilo_mdu_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hilo_mdu_ctrl : HI/LO multiply/divide sequencer with EX-stage stall       |
// | Option macro  : MDU_ITER_MUL_EN (iterative shift-add MULT/MULTU)          |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module hilo_mdu_ctrl #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [2:0]  ex_op,
   input  logic [31:0] ex_rs,
   input  logic [31:0] ex_rt,
   input  logic        ex_hold,
   input  logic        flush,
   output logic        stallreq,
   output logic        hi_we,
   output logic        lo_we,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   // a: dividend shifting out / quotient shifting in (or multiplier / product low)
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] rem_q, rem_d;
`ifdef MDU_ITER_MUL_EN
   logic        is_div_q, is_div_d;
`endif

   logic        w_signed, w_sa, w_sb, w_dvz;
   logic [31:0] w_mag_a, w_mag_b;

   assign w_signed = (ex_op == OP_MULT) || (ex_op == OP_DIV);
   assign w_sa     = w_signed & ex_rs[31];
   assign w_sb     = w_signed & ex_rt[31];
   assign w_mag_a  = w_sa ? (~ex_rs + 32'd1) : ex_rs;
   assign w_mag_b  = w_sb ? (~ex_rt + 32'd1) : ex_rt;
   assign w_dvz    = (ex_rt == 32'd0);

   // Restoring step on the 33-bit partial remainder; a zero divisor yields
   // all-ones quotient and leaves the raw dividend in the remainder.
   logic [32:0] w_rem_sh;
   logic [31:0] w_rem_sub;
   logic        w_qbit;

   assign w_rem_sh  = {rem_q, a_q[31]};
   assign w_qbit    = (w_rem_sh >= {1'b0, b_q});
   assign w_rem_sub = w_rem_sh[31:0] - b_q;

   logic [31:0] w_hi_res, w_lo_res;
   logic [31:0] w_rem_fix, w_quo_fix;

   assign w_rem_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;
   assign w_quo_fix = qneg_q ? (~a_q + 32'd1) : a_q;

`ifdef MDU_ITER_MUL_EN
   logic [32:0] w_mul_sum;
   logic [63:0] w_prod_res;

   assign w_mul_sum  = {1'b0, rem_q} + {1'b0, (a_q[0] ? b_q : 32'd0)};
   assign w_prod_res = qneg_q ? (~{rem_q, a_q} + 64'd1) : {rem_q, a_q};
   assign w_hi_res   = is_div_q ? w_rem_fix : w_prod_res[63:32];
   assign w_lo_res   = is_div_q ? w_quo_fix : w_prod_res[31:0];
`else
   logic [63:0] w_op_a, w_op_b, w_prod_comb;

   assign w_op_a      = {{32{w_sa}}, ex_rs};
   assign w_op_b      = {{32{w_sb}}, ex_rt};
   assign w_prod_comb = w_op_a * w_op_b;
   assign w_hi_res    = w_rem_fix;
   assign w_lo_res    = w_quo_fix;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
`ifdef MDU_ITER_MUL_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
`ifdef MDU_ITER_MUL_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
`ifdef MDU_ITER_MUL_EN
      is_div_d = is_div_q;
`endif
      stallreq = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      hi_out   = 32'd0;
      lo_out   = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (ex_valid && !flush) begin
               case (ex_op)
                  OP_MTHI: begin
                     hi_we  = 1'b1;
                     hi_out = ex_rs;
                  end
                  OP_MTLO: begin
                     lo_we  = 1'b1;
                     lo_out = ex_rs;
                  end
                  OP_DIV, OP_DIVU: begin
                     stallreq = 1'b1;
                     state_d  = S_BUSY;
                     cnt_d    = '0;
                     rem_d    = '0;
                     a_d      = w_dvz ? ex_rs : w_mag_a;
                     b_d      = w_mag_b;
                     qneg_d   = ~w_dvz & (w_sa ^ w_sb);
                     rneg_d   = ~w_dvz & w_sa;
`ifdef MDU_ITER_MUL_EN
                     is_div_d = 1'b1;
`endif
                  end
`ifdef MDU_ITER_MUL_EN
                  OP_MULT, OP_MULTU: begin
                     stallreq = 1'b1;
                     state_d  = S_BUSY;
                     cnt_d    = '0;
                     rem_d    = '0;
                     a_d      = w_mag_b;
                     b_d      = w_mag_a;
                     qneg_d   = w_sa ^ w_sb;
                     rneg_d   = 1'b0;
                     is_div_d = 1'b0;
                  end
`else
                  OP_MULT, OP_MULTU: begin
                     hi_we  = 1'b1;
                     lo_we  = 1'b1;
                     hi_out = w_prod_comb[63:32];
                     lo_out = w_prod_comb[31:0];
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            stallreq = 1'b1;
            cnt_d    = cnt_q + 6'd1;
`ifdef MDU_ITER_MUL_EN
            if (is_div_q) begin
               rem_d = w_qbit ? w_rem_sub : w_rem_sh[31:0];
               a_d   = {a_q[30:0], w_qbit};
            end else begin
               rem_d = w_mul_sum[32:1];
               a_d   = {w_mul_sum[0], a_q[31:1]};
            end
`else
            rem_d = w_qbit ? w_rem_sub : w_rem_sh[31:0];
            a_d   = {a_q[30:0], w_qbit};
`endif
            if (cnt_q == LAST_ITER) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_out = w_hi_res;
            lo_out = w_lo_res;
            if (!ex_hold) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything, including a same-cycle start.
      if (flush || rst) begin
         state_d  = S_IDLE;
         stallreq = 1'b0;
         hi_we    = 1'b0;
         lo_we    = 1'b0;
         hi_out   = 32'd0;
         lo_out   = 32'd0;
      end
   end

endmodule
`default_nettype wire

// File: doc/hilo_mdu_ctrl.md
# hilo_mdu_ctrl

Multi-cycle multiply/divide sequencer that owns every write into the HI/LO register pair. Sits beside the EX stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, holds the pipeline through iterative operations via a stall request, and presents one-cycle HI/LO write strobes plus data on the EX-stage HI/LO bus.

## Interface
Parameters:
- DIV_ITERS, 32, radix-2 divider iterations. Fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
- ex_rs  in  32  operand A (dividend, multiplicand, MTHI/MTLO source)
- ex_rt  in  32  operand B (divisor, multiplier)
- ex_hold  in  1  EX held by another stall source (stall[2] asserted, not caused by this block)
- flush  in  1  exception flush; aborts any operation
- stallreq  out  1  stall request to pipeline control
- hi_we  out  1  HI write strobe
- lo_we  out  1  LO write strobe
- hi_out  out  32  HI write data
- lo_out  out  32  LO write data

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE. Reset values: stallreq=0, hi_we=0, lo_we=0, hi_out=0, lo_out=0; all internal registers cleared.
- IDLE, start = ex_valid & ~flush & op∈{DIV,DIVU} (plus MULT/MULTU when iterative multiply is compiled in):
  - Latch operand magnitudes, result-sign flags, op class.
  - Clear iteration counter; stallreq=1 combinationally this cycle; → BUSY.
- IDLE, single-cycle ops, no state change, stallreq=0:
  - MTHI: hi_we=1, hi_out=ex_rs.
  - MTLO: lo_we=1, lo_out=ex_rs.
  - Combinational MULT/MULTU: hi_we=lo_we=1, {hi_out,lo_out} = 64-bit product.
- BUSY: one iteration per cycle, stallreq=1, counter increments. After 32 iterations → DONE.
- Divide: restoring, 33-bit partial remainder; one quotient bit per iteration, MSB first.
- Multiply (iterative): shift-add on magnitudes, 64-bit accumulator, one multiplier bit per iteration, LSB first.
- Signed ops:
  - Operate on magnitudes.
  - Quotient/product negated if operand signs differ.
  - Remainder takes dividend sign.
  - 0x80000000 magnitude handled as unsigned 2^31.
- Divide by zero, signed or unsigned: lo_out=0xFFFFFFFF, hi_out=ex_rs latched value; no sign correction.
- DONE:
  - stallreq=0; hi_we=lo_we=1; hi_out=remainder/product[63:32], lo_out=quotient/product[31:0].
  - If ex_hold=1, remain in DONE with outputs stable; else → IDLE.
  - The EX instruction is still present in DONE; it is not restarted.
- flush in any state: → IDLE next edge. Write strobes are 0 in the flush cycle. No HI/LO write for the aborted op.
- ex_op/ex_rs/ex_rt are ignored outside IDLE.

## Timing
- Iterative op issued at cycle T:
  - stallreq high T..T+32 (33 cycles).
  - DONE at T+33 with write strobes high and stallreq low.
  - Pipeline advances at the end of T+33.
- Single-cycle ops: strobes in the issue cycle, zero stall.
- hi_out/lo_out are valid only when the matching strobe is 1; otherwise 0.
- rst during BUSY/DONE: IDLE and all outputs 0 on the next edge.
- flush and start in the same IDLE cycle: flush wins; no start.

## Configuration
- MDU_ITER_MUL_EN defined:
  - MULT/MULTU use the 32-iteration BUSY path.
  - Same timing as divide.
  - No 32×32 multiplier is inferred.
- Undefined:
  - MULT/MULTU complete combinationally in the issue cycle with stallreq=0.
  - Only DIV/DIVU enter BUSY.

## Test plan
- DIV rs=7, rt=0xFFFFFFFE (−2) → stallreq 33 cycles; DONE: lo=0xFFFFFFFD, hi=0x00000001, strobes for exactly one cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT 0xFFFFFFFF×1 → hi=lo=0xFFFFFFFF. Run both with and without MDU_ITER_MUL_EN; check stall count is 33 or 0.
- DIVU rs=0x12345678, rt=0 → lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV started, flush at 10th BUSY cycle → next cycle IDLE, stallreq=0, no strobe ever asserted; an immediate MTLO 0xA5A5A5A5 → lo_we=1, lo_out=0xA5A5A5A5.
- DIVU 100/7 with ex_hold=1 for 3 cycles on DONE → strobes held 4 cycles (hi=2, lo=14), then IDLE, no restart.
- rst asserted mid-BUSY → all outputs 0 next cycle; a subsequent DIVU 9/3 yields lo=3, hi=0 after the full 33-cycle stall.
